// File: rtl/flash_spi_responder_pkg.sv
// flash_spi_pkg: opcodes, FSM states, field widths and JEDEC ID byte selection shared by the flash SPI responder
package flash_spi_pkg;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_JEDEC = 8'h9F;
  localparam logic [7:0] OP_RPD = 8'hAB;
  localparam int CMD_BITS = 8;
  localparam int ADDR_BITS = 24;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, IGNORE} state_t;
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    return idx == 2'd0 ? id[23:16] : idx == 2'd1 ? id[15:8] : idx == 2'd2 ? id[7:0] : 8'h00;
  endfunction
endpackage

// File: rtl/flash_spi_responder_edge_sync.sv
// spi_edge_sync: STAGES-deep synchronizers for pad csb/sck/io0 (i_*), synchronized o_csb/o_io0 and sck o_rise/o_fall pulses
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic RSTB,
  input  logic i_csb,
  input  logic i_sck,
  input  logic i_io0,
  output logic o_csb,
  output logic o_io0,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_csb, r_sck, r_io0;
  logic r_sck_d;
  always_ff @(posedge clk)
    if (RSTB) begin
      r_csb <= '1;
      r_sck <= '0;
      r_io0 <= '0;
      r_sck_d <= 1'b0;
    end else begin
      r_csb <= {r_csb[STAGES-2:0], i_csb};
      r_sck <= {r_sck[STAGES-2:0], i_sck};
      r_io0 <= {r_io0[STAGES-2:0], i_io0};
      r_sck_d <= r_sck[STAGES-1];
    end
  assign o_csb = r_csb[STAGES-1];
  assign o_io0 = r_io0[STAGES-1];
  assign o_rise = r_sck[STAGES-1] & ~r_sck_d;
  assign o_fall = ~r_sck[STAGES-1] & r_sck_d;
endmodule

// File: rtl/flash_spi_responder.sv
// flash_spi_responder: SPI flash target (READ/JEDEC/RPD) on pad csb/clk/io0 -> io1_do/oeb, preload via load_*, busy and cmd_err status
module flash_spi_responder
  import flash_spi_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              RSTB,
  input  logic              flash_csb,
  input  logic              flash_clk,
  input  logic              flash_io0,
  output logic              flash_io1_do,
  output logic              flash_io1_oeb,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic              cmd_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [7:0] r_mem [DEPTH];
  state_t r_state;
  logic [4:0] r_cnt;
  logic [6:0] r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0] r_tx;
  logic [1:0] r_idx;
  logic r_csb_d, r_do, r_oeb, r_busy, r_err;
  logic w_csb, w_io0, w_rise, w_fall, w_byte_end;
  logic [7:0] w_op;
  logic [ADDR_W-1:0] w_addr_sh, w_addr_n;
  logic [1:0] w_idx_n;
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .RSTB(RSTB), .i_csb(flash_csb), .i_sck(flash_clk), .i_io0(flash_io0),
    .o_csb(w_csb), .o_io0(w_io0), .o_rise(w_rise), .o_fall(w_fall)
  );
  assign w_op = {r_cmd, w_io0};
  assign w_addr_sh = {r_addr[ADDR_W-2:0], w_io0};
  assign w_addr_n = r_addr + 1'b1;
  assign w_idx_n = r_idx == 2'd3 ? 2'd3 : r_idx + 2'd1;
  assign w_byte_end = r_cnt == 5'd7;
  always_ff @(posedge clk)
    if (load_en && !r_busy) r_mem[load_addr] <= load_data;
  always_ff @(posedge clk)
    if (RSTB) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_do <= 1'b0;
      r_oeb <= 1'b1;
      r_busy <= 1'b0;
      r_err <= 1'b0;
      r_csb_d <= 1'b1;
    end else begin
      r_csb_d <= w_csb;
      r_err <= 1'b0;
      if (w_csb) begin
        r_state <= IDLE;
        r_cnt <= '0;
        r_do <= 1'b0;
        r_oeb <= 1'b1;
        r_busy <= 1'b0;
      end else if (r_csb_d) begin
        r_state <= CMD;
        r_cnt <= '0;
        r_busy <= 1'b1;
      end else case (r_state)
        CMD: if (w_rise) begin
          r_cmd <= w_op[6:0];
          r_cnt <= r_cnt == 5'(CMD_BITS - 1) ? '0 : r_cnt + 5'd1;
          if (r_cnt == 5'(CMD_BITS - 1)) begin
            r_state <= w_op == OP_READ ? ADDR : w_op == OP_JEDEC ? ID : IGNORE;
            r_err <= w_op != OP_READ && w_op != OP_JEDEC && w_op != OP_RPD;
            r_idx <= 2'd0;
            r_tx <= id_byte(JEDEC_ID, 2'd0);
          end
        end
        ADDR: if (w_rise) begin
          r_addr <= w_addr_sh;
          r_cnt <= r_cnt == 5'(ADDR_BITS - 1) ? '0 : r_cnt + 5'd1;
          if (r_cnt == 5'(ADDR_BITS - 1)) begin
            r_state <= DATA;
            r_tx <= r_mem[w_addr_sh];
          end
        end
        DATA, ID: if (w_fall) begin
          r_oeb <= 1'b0;
          r_do <= r_tx[7];
          r_cnt <= w_byte_end ? '0 : r_cnt + 5'd1;
          // next byte is loaded while its predecessor's last bit goes out
          r_tx <= !w_byte_end ? {r_tx[6:0], 1'b0} : r_state == DATA ? r_mem[w_addr_n] : id_byte(JEDEC_ID, w_idx_n);
          if (w_byte_end) begin
            r_addr <= w_addr_n;
            r_idx <= w_idx_n;
          end
        end
        default: ;
      endcase
    end
  assign flash_io1_do = r_do;
  assign flash_io1_oeb = r_oeb;
  assign busy = r_busy;
  assign cmd_err = r_err;
endmodule

// File: doc/flash_spi_responder.md
Name: flash_spi_responder

Overview:
- Synthesizable SPI-flash target that sits on the board/pad side of the management flash pins (flash_csb, flash_clk, flash_io0, flash_io1).
- Receives the single-bit SPI transactions the core's flash controller issues through the chip I/O pads, and answers on flash_io1.
- Serves READ (0x03), JEDEC ID (0x9F) and release power-down (0xAB) from an internal preloadable byte array.
- Used in chip-level and pad-level benches, and on FPGA bring-up, as the far end of the flash interface.

Parameters:
- ADDR_W, 10, byte-address width of internal memory; DEPTH = 2**ADDR_W.
- JEDEC_ID, 24'hEF4016, three ID bytes returned MSB-first for 0x9F.
- SYNC_STAGES, 2, synchronizer flops on flash_csb, flash_clk and flash_io0 (minimum 2).

Ports:
- clk  input  1  oversampling system clock; must run at 4x flash_clk or faster.
- RSTB  input  1  reset.
- flash_csb  input  1  chip select from pad, active-low.
- flash_clk  input  1  SPI clock from pad, mode 0.
- flash_io0  input  1  MOSI from pad.
- flash_io1_do  output  1  MISO data toward pad.
- flash_io1_oeb  output  1  MISO output enable, active-low.
- load_en  input  1  preload write strobe; accepted only while flash_csb (synchronized) is high.
- load_addr  input  ADDR_W  preload byte address.
- load_data  input  8  preload byte.
- busy  output  1  high from CS assertion until CS deassertion.
- cmd_err  output  1  one-cycle pulse when an unsupported opcode completes.

Behaviour:
- Reset RSTB, synchronous, active-high. While RSTB is high: state=IDLE, flash_io1_do=0, flash_io1_oeb=1, busy=0, cmd_err=0, bit counters=0. Memory contents are not reset.
- All three pad inputs pass through SYNC_STAGES flops.
- rise/fall = edge detect of the synchronized flash_clk, computed against the previous synchronized value.
- CS assert = falling edge of synchronized csb -> state CMD, bitcnt=0, busy=1.
- CS deassert, at any time in any state -> IDLE next cycle, flash_io1_oeb=1, busy=0. An in-flight byte is discarded.
- Mode 0 timing: io0 is sampled on rise; io1 is updated on fall.
- CMD: shift in 8 bits MSB-first. On the 8th rise, decode the opcode:
  - 0x03 -> ADDR.
  - 0x9F -> ID, idx=0.
  - 0xAB -> IGNORE.
  - Any other opcode -> IGNORE, and cmd_err pulses for exactly 1 clk.
- ADDR: shift in 24 bits. On the 24th rise, addr = low ADDR_W bits; upper bits are ignored. Then -> DATA, and the first byte is fetched the same cycle.
- DATA:
  - On the first fall after entry: flash_io1_oeb=0, flash_io1_do=byte[7].
  - Each subsequent fall shifts out the next bit.
  - After bit 0 is driven, the next fall drives bit 7 of mem[addr+1].
  - The address wraps modulo DEPTH (DEPTH-1 -> 0).
- ID: same shifting as DATA, using the JEDEC_ID bytes 0,1,2. After the third byte, io1_do=0 and oeb stays 0 until CS deassert.
- IGNORE: flash_io1_oeb=1, all clock edges are ignored until CS deassert.
- Latency: the system clock sees pad edges SYNC_STAGES+1 clk late. With the 4x ratio, the first data bit is stable at least 1 clk before the next flash_clk rise.
- Preload:
  - A load_en arriving while busy=1 is dropped.
  - A load_en coinciding with the CS assert edge is accepted; the write happens before any read can occur.
- Simultaneous rise and CS deassert in the same clk: deassert wins, no bit is captured.
- Fewer than 8 bits before deassert: no decode and no cmd_err.

Decomposition:
- Package flash_spi_pkg holds:
  - Opcode constants: OP_READ=8'h03, OP_JEDEC=8'h9F, OP_RPD=8'hAB.
  - State enum: IDLE, CMD, ADDR, DATA, ID, IGNORE.
  - Widths: CMD_BITS=8, ADDR_BITS=24.
- Sub-module spi_edge_sync: parameterized synchronizer plus rise/fall detect for flash_clk, with plain synchronization for csb and io0.
- Memory is inferred inline as an 8-bit x DEPTH array with one write port (preload) and one read port (FSM).

Test Plan:
- Preload mem[0x010..0x013]=A5,3C,F0,0F. Issue READ 0x03 addr 0x000010 and clock 32 data bits -> io1 returns A5 3C F0 0F MSB-first; oeb=1 during cmd/addr, 0 from the first post-address fall.
- Issue JEDEC 0x9F and clock 32 bits -> returns EF 40 16 00; cmd_err stays 0.
- Preload mem[DEPTH-1]=77, mem[0]=88. READ at addr 0x0003FF with 16 data bits -> 77 then 88 (wrap). Upper address bits 0xFF03FF give the same result.
- Send opcode 0x55 -> cmd_err high for exactly 1 clk after the 8th rise, oeb stays 1 until deassert; a following READ works normally.
- Raise csb after 12 address bits -> busy=0 and oeb=1 next clk. The next READ 0x000010 still returns A5.
- Assert RSTB mid-DATA -> the next clk shows oeb=1, io1_do=0, busy=0. Memory is preserved: after release, READ 0x010 returns A5. A load_en attempted while busy is ignored (the memory byte is unchanged).
